serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder/subtractor controller that sequences a single 1-bit full-adder slice, built from two `hf` half-adder instances plus an OR, over WIDTH-bit operands, LSB first, one bit per clock. A start/busy/done handshake wraps the datapath. Internal registers hold the operand shift registers, the carry flop, a bit counter and a 3-state FSM. It sits above the half-adder datapath as its sequencer and is the lab's first clocked block.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a − b); latched with the operands.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- busy  output  1  high while bits are being computed (RUN).
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle onward.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow (a ≥ b unsigned).

## Operation
- FSM states:
  - IDLE: waiting for start.
  - RUN: computing bits.
  - DONE: one-cycle result strobe.
- Transitions:
  - IDLE→RUN when start=1 at a clock edge.
  - RUN→DONE when the bit counter reaches WIDTH−1 at a clock edge.
  - DONE→IDLE unconditionally.
- Accepting start (IDLE):
  - a_sr←a; b_sr←(sub ? ~b : b); carry←sub; cnt←0.
  - sum shift register cleared to 0.
- Each RUN cycle:
  - The slice computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry), via hf(a,b) → hf(s1,carry), c = c1|c2.
  - s shifts into sum at the MSB end (sum←{s, sum[WIDTH-1:1]}).
  - a_sr and b_sr shift right by one; carry←c; cnt←cnt+1.
- On the last RUN edge, carry's final value is written to cout.
- sum and cout are held stable from DONE until the next accepted start, where sum clears. cout is held until the final RUN edge of the next operation.
- start is ignored in RUN and DONE; there is no queuing.
- a, b and sub may change freely after acceptance without affecting the result.
- Counter: $clog2(WIDTH) bits. It never wraps within an operation.

## Timing
- Reset (rst_n=0, any time, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, cnt=0, shift registers=0.
- A reset mid-RUN aborts the operation; no done pulse is issued.
- Release: the first edge with rst_n=1 may accept start.
- Let E0 be the edge that accepts start:
  - busy=1 after E0.
  - Bits 0..WIDTH−1 are computed at edges E1..E_WIDTH.
  - After E_WIDTH: busy=0, done=1, final sum/cout visible.
  - After E_WIDTH+1: done=0, state IDLE.
- Latency from start acceptance to done is WIDTH cycles.
- Earliest next acceptance is E_WIDTH+2. Back-to-back throughput is one operation per WIDTH+2 cycles.
- busy and done are never high in the same cycle; done is exactly one cycle wide.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add:
  - a=0x00, b=0x00 → sum=0x00, cout=0; done exactly 8 cycles after acceptance.
  - a=0x5A, b=0x3C → sum=0x96, cout=0.
- Carry ripple: add a=0xFF, b=0x01 → sum=0x00, cout=1.
- Subtract:
  - a=0x10, b=0x01 → sum=0x0F, cout=1.
  - a=0x00, b=0x01 → sum=0xFF, cout=0 (borrow).
- Handshake:
  - Pulse start again at cycles E3 and E_WIDTH+1 → both ignored; the original result completes; one done pulse only.
  - Change a and b during RUN → result unaffected.
- Reset mid-operation: assert rst_n=0 at E4 of a=0xFF+b=0xFF, between clock edges → busy, done, sum and cout go to 0 immediately. After release, a new add 0x01+0x02 yields 0x03, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between a requester and the bit-serial adder; start is sampled only when idle.
// Master drives the request side, slave (the adder) drives status and result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer, LSB first, one bit per clock; done pulses WIDTH cycles after start.
// No backpressure: start is only honoured in IDLE and is dropped while busy or done.
module hf (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic s1, c1, s, c2, c;

    // One full-adder slice built from two half adders.
    hf u_hf0 (.a(a_sr[0]), .b(b_sr[0]), .s(s1), .c(c1));
    hf u_hf1 (.a(s1),      .b(carry),   .s(s),  .c(c2));
    assign c = c1 | c2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= {s, sum_q[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= c;
                    if (cnt == LAST) begin
                        // Counter stops at LAST so it never wraps for power-of-two widths.
                        cout_q <= c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
